// File: rtl/clint_ctrl_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses,
// SYSTEM instruction encodings, trap causes, FSM state encoding, mstatus helpers.
package clint_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MSTATUS = 3'd2,
    S_W_MCAUSE  = 3'd3,
    S_ASSERT    = 3'd4,
    S_MRET_W    = 3'd5
  } state_e;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_ASYNC  = 32'h8000_000B;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE takes MPIE back, MPIE is set.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_ctrl_if.sv
// CSR-side bus of the interrupt controller: live CSR values in, CSR write port out.
interface clint_ctrl_if;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        global_int_en_i;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;

  modport master (
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
    output we_o, waddr_o, data_o
  );

  modport slave (
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
    input  we_o, waddr_o, data_o
  );
endinterface

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: sequences trap entry/return CSR writes and the pipeline redirect.
// Define CLINT_SYNC_EXC_EN to make ECALL/EBREAK trap; otherwise they pass through untouched.
module clint_ctrl
  import clint_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [7:0]        int_flag_i,
  input  logic              div_busy_i,
  clint_ctrl_if.master      csr_bus,
  output logic              hold_flag_o,
  output logic              int_assert_o,
  output logic [31:0]       int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic        sync_trig;
  logic [31:0] sync_cause;
  logic        is_mret;
  logic        async_req;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

`ifdef CLINT_SYNC_EXC_EN
  assign sync_trig  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign sync_cause = (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
`else
  assign sync_trig  = 1'b0;
  assign sync_cause = CAUSE_ECALL;
`endif

  assign is_mret   = (inst_i == INST_MRET);
  assign async_req = (int_flag_i != 8'h00) && csr_bus.global_int_en_i && !div_busy_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    mret_d       = mret_q;
    hold_flag_o  = 1'b1;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        hold_flag_o = 1'b0;
        // Synchronous traps beat MRET, which beats a pending async request.
        if (sync_trig) begin
          state_d     = S_W_MEPC;
          pc_d        = inst_addr_i;
          cause_d     = sync_cause;
          mret_d      = 1'b0;
          hold_flag_o = 1'b1;
        end else if (is_mret) begin
          state_d     = S_MRET_W;
          mret_d      = 1'b1;
          hold_flag_o = 1'b1;
        end else if (async_req) begin
          state_d     = S_W_MEPC;
          pc_d        = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d     = CAUSE_ASYNC;
          mret_d      = 1'b0;
          hold_flag_o = 1'b1;
        end
      end
      S_W_MEPC: begin
        we      = 1'b1;
        waddr   = CSR_MEPC;
        wdata   = pc_q;
        state_d = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        we      = 1'b1;
        waddr   = CSR_MSTATUS;
        wdata   = trap_mstatus(csr_bus.csr_mstatus_i);
        state_d = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        we      = 1'b1;
        waddr   = CSR_MCAUSE;
        wdata   = cause_q;
        state_d = S_ASSERT;
      end
      S_MRET_W: begin
        we      = 1'b1;
        waddr   = CSR_MSTATUS;
        wdata   = mret_mstatus(csr_bus.csr_mstatus_i);
        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_bus.csr_mepc_i : csr_bus.csr_mtvec_i;
        state_d      = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        hold_flag_o = 1'b0;
      end
    endcase
  end

  assign csr_bus.we_o    = we;
  assign csr_bus.waddr_o = waddr;
  assign csr_bus.data_o  = wdata;

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed self-checking bench for clint_ctrl; expectations follow CLINT_SYNC_EXC_EN when defined.
module tb_clint_ctrl;
  import clint_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] instAddr;
  logic        jumpFlag;
  logic [31:0] jumpAddr;
  logic [7:0]  intFlag;
  logic        divBusy;
  logic        holdFlag;
  logic        intAssert;
  logic [31:0] intAddr;
  logic [31:0] expEbCause;
  int          assertions;
  int          failures;

  clint_ctrl_if bus ();

  clint_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst),
    .inst_addr_i  (instAddr),
    .jump_flag_i  (jumpFlag),
    .jump_addr_i  (jumpAddr),
    .int_flag_i   (intFlag),
    .div_busy_i   (divBusy),
    .csr_bus      (bus.master),
    .hold_flag_o  (holdFlag),
    .int_assert_o (intAssert),
    .int_addr_o   (intAddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic applyStimulus(input logic r, input logic [31:0] in, input logic [31:0] pc,
                               input logic jf, input logic [31:0] ja, input logic [7:0] irq,
                               input logic busy);
    @(negedge clk);
    rst      = r;
    inst     = in;
    instAddr = pc;
    jumpFlag = jf;
    jumpAddr = ja;
    intFlag  = irq;
    divBusy  = busy;
    #1;
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eHold, input logic eWe,
                             input logic [31:0] eWaddr, input logic [31:0] eData,
                             input logic eAssert, input logic [31:0] eAddr);
    checkOne({tag, ".hold"},  {31'd0, holdFlag},    {31'd0, eHold});
    checkOne({tag, ".we"},    {31'd0, bus.we_o},    {31'd0, eWe});
    checkOne({tag, ".waddr"}, bus.waddr_o,          eWaddr);
    checkOne({tag, ".data"},  bus.data_o,           eData);
    checkOne({tag, ".int"},   {31'd0, intAssert},   {31'd0, eAssert});
    checkOne({tag, ".addr"},  intAddr,              eAddr);
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
`ifdef CLINT_SYNC_EXC_EN
    expEbCause = CAUSE_EBREAK;
`else
    expEbCause = CAUSE_ASYNC;
`endif
    rst = 1'b0; inst = NOP; instAddr = '0; jumpFlag = 1'b0; jumpAddr = '0;
    intFlag = '0; divBusy = 1'b0;
    bus.csr_mtvec_i     = 32'h200;
    bus.csr_mepc_i      = 32'h0;
    bus.csr_mstatus_i   = 32'h0;
    bus.global_int_en_i = 1'b0;

    $display("[TB] reset");
    applyStimulus(0, NOP, 0, 0, 0, 0, 0); checkOutput("reset0", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, NOP, 0, 0, 0, 0, 0); checkOutput("reset1", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 0, 0, 0, 0, 0); checkOutput("idle0",  0, 0, 0, 0, 0, 0);

    $display("[TB] async trap, no jump");
    bus.csr_mstatus_i   = 32'h8;
    bus.global_int_en_i = 1'b1;
    applyStimulus(1, NOP, 32'h100, 0, 0, 8'h01, 0); checkOutput("a_trig", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("a_mepc",    1, 1, 32'h341, 32'h100, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("a_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("a_mcause",  1, 1, 32'h342, 32'h8000000B, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("a_assert",  1, 0, 0, 0, 1, 32'h200);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("a_idle",    0, 0, 0, 0, 0, 0);

    $display("[TB] async trap with pending jump");
    applyStimulus(1, NOP, 32'h100, 1, 32'h400, 8'h80, 0); checkOutput("j_trig", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("j_mepc",    1, 1, 32'h341, 32'h400, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("j_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("j_mcause",  1, 1, 32'h342, 32'h8000000B, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("j_assert",  1, 0, 0, 0, 1, 32'h200);
    applyStimulus(1, NOP, 32'h104, 0, 0, 0, 0); checkOutput("j_idle",    0, 0, 0, 0, 0, 0);

    $display("[TB] ecall with MIE clear");
    bus.csr_mstatus_i   = 32'h0;
    bus.global_int_en_i = 1'b0;
    applyStimulus(1, INST_ECALL, 32'h40, 0, 0, 0, 0);
`ifdef CLINT_SYNC_EXC_EN
    checkOutput("e_trig", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h44, 0, 0, 0, 0); checkOutput("e_mepc",    1, 1, 32'h341, 32'h40, 0, 0);
    applyStimulus(1, NOP, 32'h44, 0, 0, 0, 0); checkOutput("e_mstatus", 1, 1, 32'h300, 32'h0, 0, 0);
    applyStimulus(1, NOP, 32'h44, 0, 0, 0, 0); checkOutput("e_mcause",  1, 1, 32'h342, CAUSE_ECALL, 0, 0);
    applyStimulus(1, NOP, 32'h44, 0, 0, 0, 0); checkOutput("e_assert",  1, 0, 0, 0, 1, 32'h200);
    applyStimulus(1, NOP, 32'h44, 0, 0, 0, 0); checkOutput("e_idle",    0, 0, 0, 0, 0, 0);
`else
    checkOutput("e_ignored", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h44, 0, 0, 0, 0); checkOutput("e_nowrite", 0, 0, 0, 0, 0, 0);
`endif

    $display("[TB] ebreak racing an async request");
    bus.csr_mstatus_i   = 32'h8;
    bus.global_int_en_i = 1'b1;
    applyStimulus(1, INST_EBREAK, 32'h80, 0, 0, 8'h04, 0); checkOutput("b_trig", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h84, 0, 0, 0, 0); checkOutput("b_mepc",    1, 1, 32'h341, 32'h80, 0, 0);
    applyStimulus(1, NOP, 32'h84, 0, 0, 0, 0); checkOutput("b_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    applyStimulus(1, NOP, 32'h84, 0, 0, 0, 0); checkOutput("b_mcause",  1, 1, 32'h342, expEbCause, 0, 0);
    applyStimulus(1, NOP, 32'h84, 0, 0, 0, 0); checkOutput("b_assert",  1, 0, 0, 0, 1, 32'h200);
    applyStimulus(1, NOP, 32'h84, 0, 0, 0, 0); checkOutput("b_idle",    0, 0, 0, 0, 0, 0);

    $display("[TB] mret wins over async request");
    bus.csr_mstatus_i = 32'h80;
    bus.csr_mepc_i    = 32'h104;
    applyStimulus(1, INST_MRET, 32'h200, 0, 0, 8'h01, 0); checkOutput("m_trig", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h204, 0, 0, 0, 0); checkOutput("m_mstatus", 1, 1, 32'h300, 32'h88, 0, 0);
    applyStimulus(1, NOP, 32'h204, 0, 0, 0, 0); checkOutput("m_assert",  1, 0, 0, 0, 1, 32'h104);
    applyStimulus(1, NOP, 32'h204, 0, 0, 0, 0); checkOutput("m_idle",    0, 0, 0, 0, 0, 0);

    $display("[TB] async deferred by divider, held through sequence");
    bus.csr_mstatus_i = 32'h8;
    applyStimulus(1, NOP, 32'h100, 0, 0, 8'h01, 1); checkOutput("d_busy0", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h100, 0, 0, 8'h01, 1); checkOutput("d_busy1", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h100, 0, 0, 8'h01, 0); checkOutput("d_trig",  1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h01, 0); checkOutput("d_mepc",    1, 1, 32'h341, 32'h100, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h01, 0); checkOutput("d_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h01, 0); checkOutput("d_mcause",  1, 1, 32'h342, 32'h8000000B, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("d_assert",  1, 0, 0, 0, 1, 32'h200);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("d_idle",    0, 0, 0, 0, 0, 0);

    $display("[TB] reset during mstatus write");
    applyStimulus(1, NOP, 32'h100, 0, 0, 8'h01, 0); checkOutput("r_trig", 1, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("r_mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    applyStimulus(0, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("r_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    applyStimulus(0, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("r_cleared", 0, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("r_idle0",   0, 0, 0, 0, 0, 0);
    applyStimulus(1, NOP, 32'h104, 0, 0, 8'h00, 0); checkOutput("r_idle1",   0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/clint_ctrl.md
CLINT_CTRL -- requirements
Module: clint_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; rst  in  1  synchronous active-low reset (asserted when low, sampled on rising clk).
REQ-002 SHALL have: inst_i  in  32  instruction in decode; inst_addr_i  in  32  its PC; jump_flag_i  in  1  ex redirect pending; jump_addr_i  in  32  redirect target.
REQ-003 SHALL have: int_flag_i  in  8  external interrupt lines, nonzero = request; div_busy_i  in  1  multicycle divide in flight.
REQ-004 SHALL have: csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  live CSR values; global_int_en_i  in  1  mstatus.MIE.
REQ-005 SHALL have: we_o  out  1; waddr_o  out  32; data_o  out  32  CSR write port (lower priority than ex port).
REQ-006 SHALL have: hold_flag_o  out  1  pipeline stall; int_assert_o  out  1  one-cycle redirect strobe; int_addr_o  out  32  redirect target.

Function
REQ-007 SHALL implement FSM states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET_W.
REQ-008 In IDLE, trigger priority SHALL be: ECALL (32'h00000073) / EBREAK (32'h00100073) > MRET (32'h30200073) > async (int_flag_i != 0 && global_int_en_i && !div_busy_i).
REQ-009 On trap trigger at edge N, SHALL latch cause and return PC, go to W_MEPC; ECALL/EBREAK return PC = inst_addr_i; async return PC = jump_flag_i ? jump_addr_i : inst_addr_i.
REQ-010 W_MEPC SHALL drive we_o=1, waddr_o=0x341, data_o=latched PC.
REQ-011 W_MSTATUS SHALL write 0x300 with csr_mstatus_i, bit7(MPIE) <= bit3, bit3(MIE) <= 0, other bits unchanged.
REQ-012 W_MCAUSE SHALL write 0x342: ECALL 32'd11, EBREAK 32'd3, async 32'h8000000B.
REQ-013 ASSERT SHALL drive int_assert_o=1, int_addr_o=csr_mtvec_i for exactly one cycle, then IDLE; trap latency = 4 cycles after trigger.
REQ-014 On MRET: MRET_W SHALL write 0x300 with bit3 <= bit7, bit7 <= 1; next cycle ASSERT with int_addr_o=csr_mepc_i.
REQ-015 hold_flag_o SHALL be 1 combinationally on trigger cycle and in every non-IDLE state, else 0.
REQ-016 Outside write states we_o=0, waddr_o=0, data_o=0; outside ASSERT int_assert_o=0, int_addr_o=0.
REQ-017 Async requests arriving while not IDLE SHALL be ignored until IDLE (level-sensitive, re-evaluated there); div_busy_i defers async only, never sync.
REQ-018 Exactly one CSR write per cycle; no state SHALL be skipped.

Reset
REQ-019 rst low SHALL force IDLE and all outputs 0 next edge, including mid-sequence; partial CSR writes are not undone.

Configuration
REQ-020 Macro CLINT_SYNC_EXC_EN defined: ECALL/EBREAK trap per REQ-008..013.
REQ-021 Macro CLINT_SYNC_EXC_EN undefined: ECALL/EBREAK ignored (no hold, no writes); MRET and async unchanged.

Structure
REQ-022 CSR addresses, MRET/ECALL/EBREAK encodings, cause constants, state encodings SHALL live in the shared defines header.
REQ-023 Single module; no sub-module.

Verification
REQ-024 mstatus=0x8, int_flag_i=0x01, inst_addr_i=0x100, no jump -> mepc<=0x100, mstatus<=0x80, mcause<=0x8000000B, int_assert_o at +4 with int_addr_o=mtvec (0x200).
REQ-025 Async with jump_flag_i=1, jump_addr_i=0x400 -> mepc<=0x400.
REQ-026 ECALL at 0x40, MIE=0 -> traps, mcause<=11; with macro undefined -> no hold, no writes.
REQ-027 MRET, mstatus=0x80, mepc=0x104 -> mstatus<=0x88, int_assert_o with int_addr_o=0x104 two cycles later.
REQ-028 int_flag_i set while div_busy_i=1 -> no trigger until div_busy_i drops, then full sequence.
REQ-029 rst low during W_MSTATUS -> next edge IDLE, hold_flag_o=0, we_o=0, no int_assert_o.
